// File: rtl/lab102_mac.sv
// Three-stage signed multiply-accumulate: operand capture, exact product, then
// pass-through or saturating accumulate with a sample counter and a sticky overflow flag.
module lab102_mac #(
  parameter  int W     = 16,
  parameter  int GUARD = 4,
  parameter  int CW    = 8,
  localparam int ACC_W = 2 * W + GUARD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [W-1:0]     din_a,
  input  logic signed [W-1:0]     din_b,
  input  logic                    mode,
  input  logic                    clr,
  output logic                    valid_out,
  output logic signed [ACC_W-1:0] dout,
  output logic [CW-1:0]           cnt,
  output logic                    sat
);

  localparam int PW = 2 * W;
  localparam int SW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1: operand capture
  logic                s1_valid_q, s1_mode_q, s1_clr_q;
  logic signed [W-1:0] s1_a_q, s1_b_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_mode_q <= mode;
        s1_clr_q  <= clr;
        s1_a_q    <= din_a;
        s1_b_q    <= din_b;
      end
    end
  end

  // Stage 2: both operands widened to 2W before multiplying, so -2^(W-1)^2 is exact
  logic                 s2_valid_q, s2_mode_q, s2_clr_q;
  logic signed [PW-1:0] s2_prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_clr_q   <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_q <= s1_mode_q;
        s2_clr_q  <= s1_clr_q;
        s2_prod_q <= PW'(s1_a_q) * PW'(s1_b_q);
      end
    end
  end

  // Stage 3: result registers
  logic                    valid_q, valid_d;
  logic signed [ACC_W-1:0] dout_q, dout_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic signed [SW-1:0]    sum_w;
  logic                    ovf_pos, ovf_neg;

  assign sum_w   = SW'(dout_q) + SW'(s2_prod_q);
  assign ovf_pos = !sum_w[SW-1] &&  sum_w[SW-2];
  assign ovf_neg =  sum_w[SW-1] && !sum_w[SW-2];

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    valid_d = s2_valid_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (s2_valid_q) begin
      if (!s2_mode_q || s2_clr_q) begin
        dout_d = ACC_W'(s2_prod_q);
        cnt_d  = CW'(1);
        sat_d  = 1'b0;
      end else begin
        if (ovf_pos)      dout_d = ACC_MAX;
        else if (ovf_neg) dout_d = ACC_MIN;
        else              dout_d = sum_w[ACC_W-1:0];
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        sat_d = sat_q | ovf_pos | ovf_neg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign valid_out = valid_q;
  assign dout      = dout_q;
  assign cnt       = cnt_q;
  assign sat       = sat_q;

endmodule
